gw2a_ddr3_rdlvl: RTL and testbench
==================================

GW2A_DDR3_RDLVL -- requirements
Module: gw2a_ddr3_rdlvl

Interface
REQ-001 SHALL have parameter LANES, default 2, number of DQS byte lanes.
REQ-002 SHALL have parameter WIDTH, default 32, read-data bits per lane per cycle.
REQ-003 SHALL have parameter PATTERN, default 32'h55AA_55AA, expected per-lane read word.
REQ-004 SHALL have parameter MAX_STEPS, default 128, DQS read-delay steps per sweep.
REQ-005 SHALL have parameter SETTLE, default 8, idle cycles after each delay move.
REQ-006 SHALL have parameter TIMEOUT, default 255, maximum cycles from rd_ack to rd_valid.
REQ-007 SHALL have ports: clock in 1, sole clock; reset_n in 1, asynchronous active-low reset.
REQ-008 SHALL have ports: start in 1, one-cycle calibration request; busy out 1; done out 1; fail out 1.
REQ-009 SHALL have ports: rd_req out 1, pattern-read request; rd_ack in 1, request accepted.
REQ-010 SHALL have ports: rd_valid in 1; rd_data in WIDTH*LANES, lane i at bits [WIDTH*i +: WIDTH].
REQ-011 SHALL have ports: dqs_rloadn out LANES; dqs_rmove out LANES; dqs_rdir out 1, 0 = increase delay.
REQ-012 SHALL have port: tap_out out 8*LANES, calibrated centre step per lane.

Function
REQ-013 SHALL calibrate lanes sequentially, lane 0 first, using FSM IDLE, LOAD, REQ, WAIT, CHECK, MOVE, SETTLE, CENTER, NEXT, DONE, FAIL.
REQ-014 IDLE: start=1 SHALL set busy=1, clear done/fail, select lane 0, enter LOAD; start while busy SHALL be ignored.
REQ-015 LOAD SHALL drive dqs_rloadn[lane]=0 for exactly 1 cycle, set step=0, clear the pass-seen flag, then enter SETTLE.
REQ-016 REQ SHALL hold rd_req=1 until the cycle rd_ack=1, then deassert rd_req in the next cycle and enter WAIT.
REQ-017 WAIT SHALL capture rd_data on the first rd_valid=1 cycle; TIMEOUT cycles without rd_valid SHALL enter FAIL.
REQ-018 CHECK: pass = (lane slice == PATTERN); first pass SHALL record first=step; each pass SHALL record last=step.
REQ-019 CHECK: a fail after a pass has been seen SHALL end the sweep and enter CENTER; otherwise enter MOVE, unless step==MAX_STEPS-1.
REQ-020 At step==MAX_STEPS-1: with a pass seen SHALL enter CENTER; with no pass seen SHALL enter FAIL.
REQ-021 MOVE SHALL pulse dqs_rmove[lane] for 1 cycle with dqs_rdir=0, increment step, then enter SETTLE.
REQ-022 SETTLE SHALL wait exactly SETTLE cycles, then enter REQ (sweep) or CENTER (centring).
REQ-023 Centre SHALL equal first + ((last-first)>>1), floor, computed at 8-bit width.
REQ-024 CENTER SHALL move back one step per MOVE/SETTLE pair with dqs_rdir=1 until step==centre, then write tap_out[lane] and enter NEXT.
REQ-025 NEXT SHALL advance the lane and enter LOAD, or enter DONE after lane LANES-1.
REQ-026 DONE SHALL set done=1 and busy=0 and return to IDLE; done SHALL stay 1 until the next accepted start.
REQ-027 FAIL SHALL set fail=1 and busy=0, leave the DQS delay as is, and return to IDLE; fail SHALL stay 1 until the next accepted start.
REQ-028 dqs_rloadn and dqs_rmove pulses SHALL target only the current lane; all other bits SHALL hold their idle values.
REQ-029 rd_valid outside WAIT SHALL be ignored.

Reset
REQ-030 reset_n=0 SHALL asynchronously force IDLE, busy=0, done=0, fail=0, rd_req=0, dqs_rloadn=all 1, dqs_rmove=0, dqs_rdir=0, tap_out=0.
REQ-031 Reset mid-calibration SHALL abort without any further DQS pulse; the PHY delay state is then undefined until the next start.

Structure
REQ-032 FSM state encoding, pattern default and the DQS direction constants SHALL live in the shared ddr3 PHY package.
REQ-033 Flat implementation; no sub-modules.

Verification
REQ-034 LANES=2; model passes steps 20..40 on lane 0 and 50..90 on lane 1 -> done=1, tap_out={8'd70,8'd30}, net rmove count per lane = centre.
REQ-035 Lane 0 passes all 128 steps -> centre 63, CENTER issues 64 rdir=1 pulses, done=1.
REQ-036 Lane 0 never passes -> 127 increment pulses, fail=1, lane 1 untouched (no rloadn pulse).
REQ-037 rd_valid withheld for 255 cycles after rd_ack -> fail=1 on timeout, busy=0.
REQ-038 reset_n low during SETTLE on lane 1 -> all outputs at reset values immediately; a new start recalibrates from lane 0.
REQ-039 start pulsed while busy, and rd_ack delayed 5 cycles -> second start ignored, rd_req held for 5 cycles, single read per step.

Source files
------------

// File: rtl/gw2a_ddr3_rdlvl_pkg.sv
// rtl/gw2a_ddr3_rdlvl_pkg.sv - shared ddr3 PHY constants for DQS read levelling
// FSM encoding, default training pattern, DQS direction codes and centre arithmetic.
package gw2a_ddr3_rdlvl_pkg;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_LOAD   = 4'd1;
  localparam logic [3:0] ST_REQ    = 4'd2;
  localparam logic [3:0] ST_WAIT   = 4'd3;
  localparam logic [3:0] ST_CHECK  = 4'd4;
  localparam logic [3:0] ST_MOVE   = 4'd5;
  localparam logic [3:0] ST_SETTLE = 4'd6;
  localparam logic [3:0] ST_CENTER = 4'd7;
  localparam logic [3:0] ST_NEXT   = 4'd8;
  localparam logic [3:0] ST_DONE   = 4'd9;
  localparam logic [3:0] ST_FAIL   = 4'd10;

  localparam logic [31:0] RDLVL_PATTERN = 32'h55AA_55AA;

  localparam logic DQS_DIR_INC = 1'b0;
  localparam logic DQS_DIR_DEC = 1'b1;

  // Midpoint of the passing window, truncated toward the first passing step.
  function automatic logic [7:0] rdlvl_centre(input logic [7:0] first, input logic [7:0] last);
    logic [7:0] span;
    span = last - first;
    return first + (span >> 1);
  endfunction

endpackage

// File: rtl/gw2a_ddr3_rdlvl_if.sv
// rtl/gw2a_ddr3_rdlvl_if.sv - pattern-read handshake and DQS delay control bundle
// master = levelling controller, slave = PHY / read datapath.
interface gw2a_ddr3_rdlvl_if #(
  parameter int LANES = 2,
  parameter int WIDTH = 32
);
  logic                     rd_req;
  logic                     rd_ack;
  logic                     rd_valid;
  logic [WIDTH*LANES-1:0]   rd_data;
  logic [LANES-1:0]         dqs_rloadn;
  logic [LANES-1:0]         dqs_rmove;
  logic                     dqs_rdir;

  modport master (
    output rd_req, dqs_rloadn, dqs_rmove, dqs_rdir,
    input  rd_ack, rd_valid, rd_data
  );

  modport slave (
    input  rd_req, dqs_rloadn, dqs_rmove, dqs_rdir,
    output rd_ack, rd_valid, rd_data
  );
endinterface

// File: rtl/gw2a_ddr3_rdlvl.sv
// rtl/gw2a_ddr3_rdlvl.sv - per-lane DQS read-delay sweep and centring
// Sweeps each lane's delay upward, finds the passing window, then backs off to its centre.
module gw2a_ddr3_rdlvl
  import gw2a_ddr3_rdlvl_pkg::*;
#(
  parameter int          LANES     = 2,
  parameter int          WIDTH     = 32,
  parameter logic [31:0] PATTERN   = RDLVL_PATTERN,
  parameter int          MAX_STEPS = 128,
  parameter int          SETTLE    = 8,
  parameter int          TIMEOUT   = 255
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [8*LANES-1:0]   tap_out,
  gw2a_ddr3_rdlvl_if.master    phy
);

  localparam int          LW           = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [7:0]  STEP_LAST    = 8'(MAX_STEPS - 1);
  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] PAT_W   = WIDTH'(PATTERN);

  logic [3:0]         state_q, state_d;
  logic [LW-1:0]      lane_q, lane_d;
  logic [7:0]         step_q, step_d, first_q, first_d, last_q, last_d;
  logic               seen_q, seen_d, centring_q, centring_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic [8*LANES-1:0] tap_q, tap_d;

  logic [7:0]         centre;
  logic               pass;
  logic [LANES-1:0]   lane_oh;

  assign centre  = rdlvl_centre(first_q, last_q);
  assign pass    = (data_q == PAT_W);
  assign lane_oh = LANES'(1) << lane_q;

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    step_d     = step_q;
    first_d    = first_q;
    last_d     = last_q;
    seen_d     = seen_q;
    centring_d = centring_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    busy_d     = busy_q;
    done_d     = done_q;
    fail_d     = fail_q;
    tap_d      = tap_q;
    case (state_q)
      ST_IDLE: if (start) begin
        busy_d  = 1'b1;
        done_d  = 1'b0;
        fail_d  = 1'b0;
        lane_d  = '0;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        step_d     = '0;
        seen_d     = 1'b0;
        centring_d = 1'b0;
        cnt_d      = '0;
        state_d    = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = centring_q ? ST_CENTER : ST_REQ;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_REQ: if (phy.rd_ack) begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (phy.rd_valid) begin
          data_d  = phy.rd_data[int'(lane_q)*WIDTH +: WIDTH];
          state_d = ST_CHECK;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_FAIL;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_CHECK: begin
        if (pass) begin
          seen_d = 1'b1;
          last_d = step_q;
          if (!seen_q) first_d = step_q;
        end
        // The window is closed by the first failing step after any pass.
        if (!pass && seen_q) begin
          centring_d = 1'b1;
          state_d    = ST_CENTER;
        end else if (step_q == STEP_LAST) begin
          if (pass || seen_q) begin
            centring_d = 1'b1;
            state_d    = ST_CENTER;
          end else begin
            state_d = ST_FAIL;
          end
        end else begin
          state_d = ST_MOVE;
        end
      end
      ST_MOVE: begin
        step_d  = centring_q ? step_q - 8'd1 : step_q + 8'd1;
        cnt_d   = '0;
        state_d = ST_SETTLE;
      end
      ST_CENTER: begin
        if (step_q == centre) begin
          tap_d[int'(lane_q)*8 +: 8] = centre;
          state_d = ST_NEXT;
        end else begin
          state_d = ST_MOVE;
        end
      end
      ST_NEXT: begin
        centring_d = 1'b0;
        if (lane_q == LW'(LANES - 1)) begin
          state_d = ST_DONE;
        end else begin
          lane_d  = lane_q + LW'(1);
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_FAIL: begin
        fail_d     = 1'b1;
        busy_d     = 1'b0;
        centring_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      lane_q     <= '0;
      step_q     <= '0;
      first_q    <= '0;
      last_q     <= '0;
      seen_q     <= 1'b0;
      centring_q <= 1'b0;
      cnt_q      <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      tap_q      <= '0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      step_q     <= step_d;
      first_q    <= first_d;
      last_q     <= last_d;
      seen_q     <= seen_d;
      centring_q <= centring_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      tap_q      <= tap_d;
    end
  end

  // Strobes decode straight from state so an async reset cannot leave a pulse behind.
  assign phy.rd_req     = (state_q == ST_REQ);
  assign phy.dqs_rloadn = (state_q == ST_LOAD) ? ~lane_oh : '1;
  assign phy.dqs_rmove  = (state_q == ST_MOVE) ? lane_oh : '0;
  assign phy.dqs_rdir   = centring_q ? DQS_DIR_DEC : DQS_DIR_INC;

  assign busy    = busy_q;
  assign done    = done_q;
  assign fail    = fail_q;
  assign tap_out = tap_q;

endmodule

// File: tb/tb_gw2a_ddr3_rdlvl.sv
// tb/tb_gw2a_ddr3_rdlvl.sv - bench for gw2a_ddr3_rdlvl with a reactive PHY model
// Expected outcomes are queued at stimulus time and scored when busy falls.
module tb_gw2a_ddr3_rdlvl;
  import gw2a_ddr3_rdlvl_pkg::*;

  localparam logic [31:0] PAT = 32'h55AA_55AA;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, fail;
  logic [15:0] tap_out;

  gw2a_ddr3_rdlvl_if #(.LANES(2), .WIDTH(32)) phy ();

  gw2a_ddr3_rdlvl #(.LANES(2), .WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .fail    (fail),
    .tap_out (tap_out),
    .phy     (phy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int  dly[2], inc_cnt[2], dec_cnt[2], load_cnt[2], lo[2], hi[2];
  int  ack_lat = 1, rd_lat = 2, req_run = 0, max_req_run = 0, reads = 0, wait_cnt = 0;
  int  first_load_lane = -1;
  bit  pend = 0, spurious = 0, acked_now;
  time ack_time = 0;

  typedef struct {
    bit          done;
    bit          fail;
    logic [15:0] tap;
    int          inc0, dec0, dly0, load1;
    bit          chk_l1;
    int          dly1, inc1;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] exp_tap = 16'h0;
  logic        busy_prev = 1'b0;

  initial begin
    phy.rd_ack   = 1'b0;
    phy.rd_valid = 1'b0;
    phy.rd_data  = '0;
  end

  // PHY model: tracks delay taps from strobes and answers pattern reads.
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (phy.dqs_rloadn[i] == 1'b0) begin
        dly[i] = 0;
        load_cnt[i]++;
        if (first_load_lane < 0) first_load_lane = i;
      end
      if (phy.dqs_rmove[i]) begin
        if (phy.dqs_rdir) begin dly[i]--; dec_cnt[i]++; end
        else begin dly[i]++; inc_cnt[i]++; end
      end
    end
    phy.rd_ack   = 1'b0;
    phy.rd_valid = 1'b0;
    acked_now    = 1'b0;
    if (!reset_n) begin
      pend    = 1'b0;
      req_run = 0;
    end else begin
      if (phy.rd_req) begin
        req_run++;
        if (req_run > max_req_run) max_req_run = req_run;
        if (req_run == ack_lat) begin
          phy.rd_ack = 1'b1;
          acked_now  = 1'b1;
          reads++;
          pend     = 1'b1;
          wait_cnt = 0;
          ack_time = $time;
        end
      end else begin
        req_run = 0;
      end
      if (pend && !acked_now) begin
        wait_cnt++;
        if (rd_lat != 0 && wait_cnt == rd_lat) begin
          for (int i = 0; i < 2; i++)
            phy.rd_data[32*i +: 32] = (dly[i] >= lo[i] && dly[i] <= hi[i]) ? PAT : ~PAT;
          phy.rd_valid = 1'b1;
          pend = 1'b0;
        end
      end else if (spurious && !pend && !acked_now) begin
        phy.rd_valid = 1'($urandom_range(0, 1));
        phy.rd_data  = ~{PAT, PAT};
      end
    end
  end

  // Scoreboard: each completed calibration retires one queued expectation.
  always @(negedge clock) begin
    if (reset_n && busy_prev && !busy) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected_end queue empty when busy fell");
      end else begin
        mon_e = sb.pop_front();
        checks++; if (done !== mon_e.done) begin errors++; $display("FAIL sb_done got=%0b exp=%0b", done, mon_e.done); end
        checks++; if (fail !== mon_e.fail) begin errors++; $display("FAIL sb_fail got=%0b exp=%0b", fail, mon_e.fail); end
        checks++; if (tap_out !== mon_e.tap) begin errors++; $display("FAIL sb_tap got=%h exp=%h", tap_out, mon_e.tap); end
        checks++; if (inc_cnt[0] != mon_e.inc0) begin errors++; $display("FAIL sb_inc0 got=%0d exp=%0d", inc_cnt[0], mon_e.inc0); end
        checks++; if (dec_cnt[0] != mon_e.dec0) begin errors++; $display("FAIL sb_dec0 got=%0d exp=%0d", dec_cnt[0], mon_e.dec0); end
        checks++; if (dly[0] != mon_e.dly0) begin errors++; $display("FAIL sb_dly0 got=%0d exp=%0d", dly[0], mon_e.dly0); end
        checks++; if (load_cnt[1] != mon_e.load1) begin errors++; $display("FAIL sb_load1 got=%0d exp=%0d", load_cnt[1], mon_e.load1); end
        if (mon_e.chk_l1) begin
          checks++; if (dly[1] != mon_e.dly1) begin errors++; $display("FAIL sb_dly1 got=%0d exp=%0d", dly[1], mon_e.dly1); end
          checks++; if (inc_cnt[1] != mon_e.inc1) begin errors++; $display("FAIL sb_inc1 got=%0d exp=%0d", inc_cnt[1], mon_e.inc1); end
        end
      end
    end
    busy_prev = busy;
  end

  function automatic int centre_of(input int l, input int h);
    int e;
    e = (h >= 127) ? 127 : h;
    return l + (e - l) / 2;
  endfunction

  function automatic int sweep_end(input int h);
    return (h >= 127) ? 127 : h + 1;
  endfunction

  task automatic clear_model(input int l0, input int h0, input int l1, input int h1);
    lo[0] = l0; hi[0] = h0; lo[1] = l1; hi[1] = h1;
    for (int i = 0; i < 2; i++) begin inc_cnt[i] = 0; dec_cnt[i] = 0; load_cnt[i] = 0; end
    max_req_run = 0; reads = 0; first_load_lane = -1;
  endtask

  task automatic push_pass(input int l0, input int h0, input int l1, input int h1);
    exp_t e;
    int   c0, c1;
    c0 = centre_of(l0, h0);
    c1 = centre_of(l1, h1);
    e.done = 1'b1; e.fail = 1'b0;
    e.tap  = {8'(c1), 8'(c0)};
    e.inc0 = sweep_end(h0); e.dec0 = sweep_end(h0) - c0; e.dly0 = c0;
    e.load1 = 1; e.chk_l1 = 1'b1; e.dly1 = c1; e.inc1 = sweep_end(h1);
    exp_tap = e.tap;
    sb.push_back(e);
  endtask

  task automatic push_fail(input int inc0, input int dly0);
    exp_t e;
    e.done = 1'b0; e.fail = 1'b1; e.tap = exp_tap;
    e.inc0 = inc0; e.dec0 = 0; e.dly0 = dly0; e.load1 = 0;
    e.chk_l1 = 1'b0; e.dly1 = 0; e.inc1 = 0;
    sb.push_back(e);
  endtask

  task automatic run_cal(input int restart_after, output time t_end);
    int n;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    n = 0;
    while (!busy && n < 10) begin @(negedge clock); n++; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_accept busy=%b exp=1", busy); end
    if (restart_after > 0) begin
      repeat (restart_after) @(negedge clock);
      start = 1'b1;
      @(negedge clock); start = 1'b0;
    end
    n = 0;
    while (busy && n < 30000) begin @(negedge clock); n++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL run_timeout busy=%b exp=0", busy); end
    t_end = $time;
    @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL rst_fail got=%b exp=0", fail); end
    checks++; if (phy.rd_req !== 1'b0) begin errors++; $display("FAIL rst_rd_req got=%b exp=0", phy.rd_req); end
    checks++; if (phy.dqs_rloadn !== 2'b11) begin errors++; $display("FAIL rst_rloadn got=%b exp=11", phy.dqs_rloadn); end
    checks++; if (phy.dqs_rmove !== 2'b00) begin errors++; $display("FAIL rst_rmove got=%b exp=00", phy.dqs_rmove); end
    checks++; if (phy.dqs_rdir !== 1'b0) begin errors++; $display("FAIL rst_rdir got=%b exp=0", phy.dqs_rdir); end
    checks++; if (tap_out !== 16'h0) begin errors++; $display("FAIL rst_tap got=%h exp=0000", tap_out); end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_two_lanes();
    time t;
    ack_lat = 1; rd_lat = 2; spurious = 1'b0;
    clear_model(20, 40, 50, 90);
    push_pass(20, 40, 50, 90);
    run_cal(0, t);
    checks++; if (tap_out !== {8'd70, 8'd30}) begin errors++; $display("FAIL two_tap got=%h exp=461e", tap_out); end
    checks++; if (dec_cnt[1] != 21) begin errors++; $display("FAIL two_dec1 got=%0d exp=21", dec_cnt[1]); end
  endtask

  task automatic test_all_pass();
    time t;
    clear_model(0, 127, 50, 90);
    push_pass(0, 127, 50, 90);
    run_cal(0, t);
    checks++; if (dec_cnt[0] != 64) begin errors++; $display("FAIL allp_dec0 got=%0d exp=64", dec_cnt[0]); end
    checks++; if (tap_out[7:0] !== 8'd63) begin errors++; $display("FAIL allp_tap0 got=%0d exp=63", tap_out[7:0]); end
  endtask

  task automatic test_never_pass();
    time t;
    clear_model(200, -1, 50, 90);
    push_fail(127, 127);
    run_cal(0, t);
    checks++; if (fail !== 1'b1) begin errors++; $display("FAIL never_fail got=%b exp=1", fail); end
    checks++; if (load_cnt[1] != 0) begin errors++; $display("FAIL never_load1 got=%0d exp=0", load_cnt[1]); end
  endtask

  task automatic test_timeout();
    time t;
    rd_lat = 0;
    clear_model(20, 40, 50, 90);
    push_fail(0, 0);
    run_cal(0, t);
    checks++; if (reads != 1) begin errors++; $display("FAIL to_reads got=%0d exp=1", reads); end
    checks++; if (t - ack_time != 2570) begin errors++; $display("FAIL to_latency got=%0t exp=2570", t - ack_time); end
    rd_lat = 2;
  endtask

  task automatic test_reset_mid();
    time t;
    int  n, inc_s, dec_s, ld_s;
    clear_model(20, 40, 50, 90);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    n = 0;
    while (load_cnt[1] == 0 && n < 20000) begin @(negedge clock); n++; end
    checks++; if (load_cnt[1] == 0) begin errors++; $display("FAIL mid_reach_lane1 got=0 exp=1"); end
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({busy, done, fail, phy.rd_req, phy.dqs_rdir} !== 5'b0) begin errors++; $display("FAIL mid_flags got=%b exp=00000", {busy, done, fail, phy.rd_req, phy.dqs_rdir}); end
    checks++; if ({phy.dqs_rloadn, phy.dqs_rmove} !== 4'b1100) begin errors++; $display("FAIL mid_strobes got=%b exp=1100", {phy.dqs_rloadn, phy.dqs_rmove}); end
    checks++; if (tap_out !== 16'h0) begin errors++; $display("FAIL mid_tap got=%h exp=0000", tap_out); end
    inc_s = inc_cnt[0] + inc_cnt[1]; dec_s = dec_cnt[0] + dec_cnt[1]; ld_s = load_cnt[0] + load_cnt[1];
    repeat (5) @(negedge clock);
    checks++; if (inc_cnt[0] + inc_cnt[1] + dec_cnt[0] + dec_cnt[1] + load_cnt[0] + load_cnt[1] != inc_s + dec_s + ld_s)
      begin errors++; $display("FAIL mid_no_pulse got=%0d exp=%0d", inc_cnt[0] + inc_cnt[1] + dec_cnt[0] + dec_cnt[1] + load_cnt[0] + load_cnt[1], inc_s + dec_s + ld_s); end
    reset_n = 1'b1;
    exp_tap = 16'h0;
    clear_model(20, 40, 50, 90);
    push_pass(20, 40, 50, 90);
    run_cal(0, t);
    checks++; if (first_load_lane != 0) begin errors++; $display("FAIL mid_restart_lane got=%0d exp=0", first_load_lane); end
  endtask

  task automatic test_back_to_back();
    time t;
    ack_lat = 5; rd_lat = 3; spurious = 1'b1;
    clear_model(20, 40, 50, 90);
    push_pass(20, 40, 50, 90);
    run_cal(3, t);
    checks++; if (max_req_run != 5) begin errors++; $display("FAIL b2b_req_hold got=%0d exp=5", max_req_run); end
    checks++; if (reads != 134) begin errors++; $display("FAIL b2b_reads got=%0d exp=134", reads); end
    checks++; if (load_cnt[0] != 1) begin errors++; $display("FAIL b2b_load0 got=%0d exp=1", load_cnt[0]); end
    spurious = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_two_lanes();
    test_all_pass();
    test_never_pass();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
